click_sync_rx: RTL

Synchronous receiver for the two-phase (transition-signalling) bundled-data channel produced by a click-based asynchronous pipeline.
- Synchronises the incoming request, captures the bundled data word and buffers it in a small FIFO.
- Returns a two-phase acknowledge to the click stage.
- Presents words to clocked logic on a valid/ready interface.
- Sits at the boundary where a click pipeline drains into the synchronous domain.

---
 rtl/click_sync_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/click_sync_rx.sv
// -----------------------------------------------------------------------------
// click_sync_rx
//
// Receiver for the two-phase (transition-signalling) bundled-data channel that
// leaves a click-based asynchronous pipeline. A new word is offered whenever
// the request line toggles. The receiver does four things:
//   - brings the request into the i_clk domain
//   - writes the bundled word into a small FIFO
//   - returns a two-phase acknowledge to the click stage
//   - presents the FIFO head on a valid/ready interface
//
// Build option:
//   CLICK_RX_SYNC_EN  defined   : i_req passes through SYNC_STAGES flops before
//                                 use (required for a truly asynchronous source).
//                     undefined : i_req is used directly (click stage already
//                                 clocked by i_clk); SYNC_STAGES is ignored.
//
// Parameters:
//   DWIDTH       width of the bundled data word
//   DEPTH        FIFO depth in words (power of two, >= 2)
//   SYNC_STAGES  request synchroniser length (>= 2)
//
// Ports:
//   i_clk    receiver clock, all state updates on rising edge
//   i_rstn   synchronous active-low reset; clears sync flops, pointers,
//            memory and acknowledge
//   i_req    two-phase request; each transition marks a new word
//   i_data   bundled data, stable whenever i_req != o_ack
//   o_ack    two-phase acknowledge, toggles once per accepted word (flop)
//   o_data   FIFO head word
//   o_valid  FIFO non-empty
//   i_ready  consumer takes the head word when o_valid && i_ready
// -----------------------------------------------------------------------------
module click_sync_rx #(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_ack,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit distinguishes full from empty when the
  // address bits are equal.
  localparam int PW = AW + 1;

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  logic req_s;

`ifdef CLICK_RX_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_req};
    end
  end

  assign req_s = sync_reg[SYNC_STAGES-1];
`else
  assign req_s = i_req;
`endif

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     wptr_reg;
  logic [PW-1:0]     rptr_reg;
  logic              ack_reg;
  logic [DWIDTH-1:0] mem_reg [DEPTH];

  logic empty;
  logic full;
  logic pending;
  logic push;
  logic pop;

  assign empty   = (wptr_reg == rptr_reg);
  assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

  // An outstanding transition exists while the synchronised request and
  // our acknowledge disagree. Toggling ack on the push edge clears it,
  // so each request transition yields exactly one push.
  assign pending = req_s ^ ack_reg;

  // Full blocks the push even when a pop happens on the same edge. The
  // stalled word is taken on the next edge, once the freed slot shows in
  // the registered pointers.
  assign push    = pending && !full;
  assign pop     = !empty && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      ack_reg  <= 1'b0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + PW'(1);
        ack_reg  <= ~ack_reg;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PW'(1);
      end
    end
  end

  // Storage is cleared on reset so the head word reads 0 afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[wptr_reg[AW-1:0]] <= i_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ack   = ack_reg;
  assign o_valid = !empty;
  assign o_data  = mem_reg[rptr_reg[AW-1:0]];

endmodule
